usb_tx_line: RTL and testbench

- Full-speed USB transmit line driver: the transmitting counterpart to the receive-side EOP/line logic.
- Accepts packet bytes over a valid/ready handshake and prepends SYNC.
- Serialises the bytes LSB-first with bit stuffing and NRZI encoding, drives d_plus/d_minus, and terminates each packet with EOP (SE0, SE0, J).
- Sits between the packet/PID builder and the transceiver pads.

---
 rtl/usb_tx_pkg.sv | 21 ++
 rtl/usb_tx_bit_timer.sv | 32 +++
 rtl/usb_tx_line.sv | 165 ++++++++++++++++
 tb/tb_usb_tx_line.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the full-speed USB transmit line driver.
// Line pairs are packed as {d_plus, d_minus}.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StData,
    StEopSe0,
    StEopJ
  } tx_state_t;

  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  localparam logic [7:0]  SYNC_BYTE    = 8'h80;
  localparam int unsigned STUFF_LIMIT  = 6;
  localparam int unsigned EOP_SE0_BITS = 2;

endpackage

// File: rtl/usb_tx_bit_timer.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module usb_tx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign bit_end = (cnt_q == CntW'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clear || bit_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/usb_tx_line.sv
// Full-speed USB transmit line driver: SYNC, LSB-first data with bit stuffing and NRZI,
// then EOP. The byte latched in IDLE is the first data byte; later bytes are pulled per byte.
module usb_tx_line
  import usb_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       d_plus,
  output logic       d_minus,
  output logic       d_oe,
  output logic       tx_busy,
  output logic       tx_error
);

  tx_state_t  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic       last_q, last_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] ones_q, ones_d;
  logic       level_q, level_d;  // NRZI level, 1 = J
  logic [1:0] eop_cnt_q, eop_cnt_d;
  logic [1:0] line_q, line_d;
  logic       oe_q, oe_d;

  logic       bit_end, stuff_owed, byte_done;
  logic       send_en, send_bit;
  logic [7:0] src;
  logic [2:0] nxt_idx;

  usb_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q == StIdle),
    .bit_end(bit_end)
  );

  assign stuff_owed = (ones_q == 3'(STUFF_LIMIT));
  assign byte_done  = bit_end && (bit_cnt_q == 3'd7) && !stuff_owed;
  assign tx_ready   = (state_q == StIdle) || ((state_q == StData) && byte_done && !last_q);
  assign tx_error   = (state_q == StData) && tx_ready && !tx_valid;
  assign tx_busy    = (state_q != StIdle);
  assign d_plus     = line_q[1];
  assign d_minus    = line_q[0];
  assign d_oe       = oe_q;

  assign src     = (state_q == StSync) ? SYNC_BYTE : shift_q;
  assign nxt_idx = bit_cnt_q + 3'd1;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    last_d    = last_q;
    bit_cnt_d = bit_cnt_q;
    ones_d    = ones_q;
    level_d   = level_q;
    eop_cnt_d = eop_cnt_q;
    line_d    = line_q;
    oe_d      = oe_q;
    send_en   = 1'b0;
    send_bit  = 1'b0;

    unique case (state_q)
      StIdle: begin
        line_d = LINE_J;
        oe_d   = 1'b0;
        if (tx_valid) begin
          shift_d   = tx_data;
          last_d    = tx_last;
          state_d   = StSync;
          oe_d      = 1'b1;
          bit_cnt_d = 3'd0;
          send_en   = 1'b1;
          send_bit  = SYNC_BYTE[0];
        end
      end
      StSync, StData: begin
        if (bit_end) begin
          if (stuff_owed) begin
            // Stuffed 0: same bit index, just an extra toggled period.
            send_en  = 1'b1;
            send_bit = 1'b0;
          end else if (bit_cnt_q != 3'd7) begin
            bit_cnt_d = nxt_idx;
            send_en   = 1'b1;
            send_bit  = src[nxt_idx];
          end else if (state_q == StSync) begin
            state_d   = StData;
            bit_cnt_d = 3'd0;
            send_en   = 1'b1;
            send_bit  = shift_q[0];
          end else if (!last_q && tx_valid) begin
            shift_d   = tx_data;
            last_d    = tx_last;
            bit_cnt_d = 3'd0;
            send_en   = 1'b1;
            send_bit  = tx_data[0];
          end else begin
            // Last byte finished or underrun.
            state_d   = StEopSe0;
            line_d    = LINE_SE0;
            level_d   = 1'b1;
            ones_d    = 3'd0;
            eop_cnt_d = 2'd0;
          end
        end
      end
      StEopSe0: begin
        if (bit_end) begin
          if (eop_cnt_q == 2'(EOP_SE0_BITS - 1)) begin
            state_d = StEopJ;
            line_d  = LINE_J;
          end else begin
            eop_cnt_d = eop_cnt_q + 2'd1;
          end
        end
      end
      StEopJ: begin
        if (bit_end) begin
          state_d = StIdle;
          oe_d    = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (send_en) begin
      level_d = send_bit ? level_q : !level_q;
      ones_d  = send_bit ? (ones_q + 3'd1) : 3'd0;
      line_d  = level_d ? LINE_J : LINE_K;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      shift_q   <= 8'h00;
      last_q    <= 1'b0;
      bit_cnt_q <= 3'd0;
      ones_q    <= 3'd0;
      level_q   <= 1'b1;
      eop_cnt_q <= 2'd0;
      line_q    <= LINE_J;
      oe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      last_q    <= last_d;
      bit_cnt_q <= bit_cnt_d;
      ones_q    <= ones_d;
      level_q   <= level_d;
      eop_cnt_q <= eop_cnt_d;
      line_q    <= line_d;
      oe_q      <= oe_d;
    end
  end

endmodule

// File: tb/tb_usb_tx_line.sv
// Bench for usb_tx_line: table of directed packets plus random packets, each checked
// cycle by cycle against a symbol-list model built from the stuffing/NRZI rules.
module tb_usb_tx_line;

  localparam int unsigned CPB = 4;
  localparam logic [1:0] SJ   = 2'b10;
  localparam logic [1:0] SK   = 2'b01;
  localparam logic [1:0] SSE0 = 2'b00;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_ready, d_plus, d_minus, d_oe, tx_busy, tx_error;

  int n_vec = 0;
  int n_err = 0;

  usb_tx_line #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .tx_last (tx_last),
    .tx_ready(tx_ready),
    .d_plus  (d_plus),
    .d_minus (d_minus),
    .d_oe    (d_oe),
    .tx_busy (tx_busy),
    .tx_error(tx_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;      // byte k in data[8k +: 8]
    int          n;         // bytes offered
    bit          under;     // final byte offered without tx_last, then tx_valid dropped
    int          exp_syms;  // total line symbols incl. SYNC and EOP
  } vec_t;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_line"}, {14'd0, d_plus, d_minus}, {14'd0, SJ});
    chk({tag, "_oe"}, {15'd0, d_oe}, 16'd0);
    chk({tag, "_ready"}, {15'd0, tx_ready}, 16'd1);
    chk({tag, "_busy"}, {15'd0, tx_busy}, 16'd0);
    chk({tag, "_err"}, {15'd0, tx_error}, 16'd0);
  endtask

  // Called at #1 after a posedge with the DUT idle.
  task automatic run_packet(input logic [31:0] data, input int n, input bit under,
                            input int exp_syms);
    logic [1:0] q[$];
    int         ends[$];
    int         rdy[$];
    logic [7:0] v;
    logic       level;
    int         ones, err_c, idx, oe_cycles, total;
    logic [1:0] es;
    logic       eo, er, ee, hs;

    level = 1'b1;
    ones  = 0;
    err_c = -1;
    for (int k = 0; k <= n; k++) begin
      v = (k == 0) ? 8'h80 : data[8*(k-1) +: 8];
      for (int i = 0; i < 8; i++) begin
        if (v[i] == 1'b0) begin
          level = ~level;
          ones  = 0;
        end else begin
          ones++;
        end
        q.push_back(level ? SJ : SK);
        if (ones == 6) begin
          level = ~level;
          ones  = 0;
          q.push_back(level ? SJ : SK);
        end
      end
      if (k > 0) ends.push_back(q.size() - 1);
    end
    for (int k = 0; k < n; k++) begin
      if (k < n - 1 || under) rdy.push_back(4 * ends[k] + 3);
    end
    if (under) err_c = 4 * ends[n-1] + 3;
    q.push_back(SSE0);
    q.push_back(SSE0);
    q.push_back(SJ);
    if (exp_syms < 0) exp_syms = q.size();

    chk("pre_ready", {15'd0, tx_ready}, 16'd1);
    tx_valid = 1'b1;
    tx_data  = data[7:0];
    tx_last  = (n == 1) && !under;
    idx      = 0;
    hs       = 1'b1;
    oe_cycles = 0;
    total    = 4 * q.size() + 3;
    for (int c = 0; c < total; c++) begin
      @(posedge clk);
      #1;
      if (hs) begin
        idx++;
        if (idx < n) begin
          tx_data = data[8*idx +: 8];
          tx_last = (idx == n - 1) && !under;
        end else begin
          tx_valid = 1'b0;
        end
      end
      if (c < 4 * q.size()) begin
        es = q[c / 4];
        eo = 1'b1;
        er = 1'b0;
        foreach (rdy[r]) if (rdy[r] == c) er = 1'b1;
        ee = (c == err_c);
      end else begin
        es = SJ;
        eo = 1'b0;
        er = 1'b1;
        ee = 1'b0;
      end
      if (d_oe) oe_cycles++;
      chk("line", {14'd0, d_plus, d_minus}, {14'd0, es});
      chk("oe", {15'd0, d_oe}, {15'd0, eo});
      chk("busy", {15'd0, tx_busy}, {15'd0, eo});
      chk("ready", {15'd0, tx_ready}, {15'd0, er});
      chk("error", {15'd0, tx_error}, {15'd0, ee});
      hs = tx_valid && tx_ready;
    end
    chk("oe_cycles", 16'(oe_cycles), 16'(4 * exp_syms));
    tx_valid = 1'b0;
  endtask

  vec_t tbl[7];

  initial begin
    logic [31:0] rdata;
    int          rn;
    bit          ru;

    tbl[0] = '{32'h0000_00C3, 1, 1'b0, 19};
    tbl[1] = '{32'h0000_01FF, 2, 1'b0, 28};
    tbl[2] = '{32'h0000_003F, 1, 1'b0, 20};
    tbl[3] = '{32'h0000_00FC, 1, 1'b0, 20};
    tbl[4] = '{32'h0000_00FC, 2, 1'b0, 28};
    tbl[5] = '{32'h0000_00A5, 1, 1'b1, 19};
    tbl[6] = '{32'h00FF_FFFF, 3, 1'b0, 39};

    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk_idle("reset_idle");
    end

    foreach (tbl[t]) begin
      run_packet(tbl[t].data, tbl[t].n, tbl[t].under, tbl[t].exp_syms);
    end

    // Reset in the middle of the first data byte drops the packet without EOP.
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    tx_last  = 1'b0;
    @(posedge clk);
    #1;
    tx_data = 8'h5A;
    tx_last = 1'b1;
    repeat (45) @(posedge clk);
    #1;
    chk("mid_oe_before", {15'd0, d_oe}, 16'd1);
    rst      = 1'b1;
    tx_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_idle("mid_reset");
    rst = 1'b0;
    run_packet(32'h0000_00C3, 1, 1'b0, 19);

    for (int p = 0; p < 40; p++) begin
      for (int k = 0; k < 4; k++) begin
        rdata[8*k +: 8] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      end
      rn = 1 + $urandom_range(0, 2);
      ru = ($urandom_range(0, 3) == 0);
      run_packet(rdata, rn, ru, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
